s2p_multi: RTL
==============

# s2p_multi

Parametrised multi-channel serial-to-parallel converter for the MSDAP input path. It oversamples the 768 kHz `DCLK`, `Frame` and `CHANNELS` serial lines in the single `SCLK` (26.88 MHz) domain, with optional frame-sync word alignment. It delivers `WIDTH`-bit words on all channels at once through a valid/ready handshake, with overrun and frame-error reporting. It replaces the fixed two-channel, 16-bit, dual-clock converter in front of the filter core.

## Interface
- `WIDTH`, 16: bits per word, MSB first; legal range 2..32.
- `CHANNELS`, 2: number of serial lanes; channel 0 = Left, 1 = Right.
- `SYNC_STAGES`, 2: synchroniser depth for `DCLK`, `Frame`, `Serial`; minimum 2.

Ports:
- `SCLK`, input, 1: system clock; the only clock.
- `clear`, input, 1: asynchronous, active-low reset.
- `DCLK`, input, 1: serial bit clock, asynchronous to `SCLK`; data is valid at its falling edge.
- `Frame`, input, 1: frame sync; high during the MSB bit of a word.
- `Serial`, input, `CHANNELS`: serial data, one bit per channel.
- `Parallel`, output, `CHANNELS*WIDTH`: output words; channel c occupies bits `[c*WIDTH +: WIDTH]`.
- `out_valid`, output, 1: `Parallel` holds an unaccepted word.
- `out_ready`, input, 1: consumer accepts the word when `out_valid & out_ready`.
- `overrun`, output, 1: one-cycle pulse when a pending word is overwritten.
- `frame_err`, output, 1: one-cycle pulse when `Frame` arrives mid-word.

## Operation
- **Synchronisation:**
  - `DCLK`, `Frame` and `Serial` each pass through identical `SYNC_STAGES` flop chains, so they stay mutually aligned.
  - A sample strobe `samp` is high for one `SCLK` cycle when synchronised `DCLK` goes from 1 to 0.
- **Shift:**
  - On `samp`, each channel shift register takes `{sr[WIDTH-2:0], Serial[c]}`.
  - The bit counter `cnt` (width $clog2(WIDTH)) increments.
- **FSM** (when alignment is enabled):
  - HUNT, on `samp` with `Frame`=1: capture the bit as MSB, set `cnt`=1, go to SHIFT. On `samp` with `Frame`=0: the bit is discarded.
  - SHIFT, on `samp` with `Frame`=1 and `cnt`≠0: pulse `frame_err`, discard the partial word, capture the bit as the new MSB, set `cnt`=1, stay in SHIFT.
  - SHIFT, on `samp` with `cnt`==WIDTH-1: the word is complete; set `cnt`=0 and go to HUNT.
  - A `Frame` on the bit immediately after a completed word is therefore accepted with no error, which gives back-to-back frames.
- **Completion:**
  - The output register loads the full word (including the bit just sampled) for all channels together.
  - `out_valid` is set.
- **Handshake:**
  - `out_valid` stays high until `out_valid & out_ready`; it then clears, unless a completion occurs in the same cycle.
  - Completion with `out_valid`=1 and `out_ready`=0: the new word overwrites, `out_valid` stays 1, and `overrun` pulses.
  - Completion with an accepting `out_ready` in the same cycle: the old word is consumed, the new word loads, `out_valid` stays 1, and there is no overrun.
  - `Parallel` is stable while `out_valid`=1 and no completion occurs.
- **Reset** (`clear`=0, any time including mid-word):
  - Synchronisers, shift registers and `cnt` go to 0; the FSM goes to HUNT.
  - `Parallel`=0, `out_valid`=0, `overrun`=0, `frame_err`=0.
  - After release, the first `samp` requires a synchronised falling edge seen after reset; the synchroniser reset value 0 must not fake an edge.

## Timing
- `samp` is asserted SYNC_STAGES+1 `SCLK` edges after the `DCLK` falling edge.
- `Parallel`/`out_valid` update on the `SCLK` edge ending the `samp` cycle of the last bit. Total latency is SYNC_STAGES+2 edges after the last `DCLK` fall.
- `overrun` and `frame_err` are registered and coincide with that update edge.
- Requirement: each `DCLK` phase is ≥ SYNC_STAGES+2 `SCLK` periods. The nominal ratio is 35.
- `Serial`/`Frame` must be stable for ≥ 2 `SCLK` periods around the `DCLK` fall.

## Configuration
- Macro: `S2P_FRAME_ALIGN_EN`.
- **Defined:** the HUNT/SHIFT alignment above is active, and `frame_err` is live.
- **Undefined:**
  - There is no HUNT state; the block leaves reset free-running with `cnt`=0.
  - Every WIDTH-th `samp` completes a word.
  - `Frame` is ignored and `frame_err` is tied to 0.

## Structure
- Package `s2p_pkg`:
  - the `s2p_state_e` enum (HUNT, SHIFT);
  - default constants `S2P_WIDTH_DEF`=16, `S2P_CHANNELS_DEF`=2, `S2P_SYNC_DEF`=2.
- Sub-module `s2p_edge_sync`: a parametrised-depth synchroniser bank for `DCLK`, `Frame` and `Serial`, plus the `DCLK` falling-edge detector that outputs `samp`. It is instantiated once.

## Test plan
- **Aligned word:** WIDTH=16, CHANNELS=2, `Frame` on the first bit, L=0xA5C3, R=0x1234, `out_ready`=1. Expect `Parallel`={0x1234,0xA5C3} with a one-cycle `out_valid` at SYNC_STAGES+2 edges after the 16th `DCLK` fall.
- **Backpressure/overrun:** `out_ready`=0 across two words (0x0001 then 0xFFFF). Expect `out_valid` to stay 1, `Parallel` to become 0xFFFF, and one `overrun` pulse. Raising `out_ready` then clears `out_valid` after one cycle.
- **Simultaneous accept and complete:** `out_ready` pulses in the completion cycle of word 2. Expect no `overrun`, `out_valid` continuously 1, and word 2 presented.
- **Mid-word frame:** `Frame` reasserted at bit 7. Expect a `frame_err` pulse, then the next 16 bits from that point to form the word, which is 0xBEEF.
- **Hunt:** 5 noise bits with `Frame`=0 before the first `Frame`. Expect no `out_valid` until 16 bits after `Frame`. With `S2P_FRAME_ALIGN_EN` undefined, expect a word after the 16th bit regardless of `Frame`.
- **Reset mid-word:** `clear`=0 at bit 9. Expect all outputs at 0 immediately and no spurious `samp` after release. The next framed word 0x5A5A arrives intact.

Source files
------------

// File: rtl/s2p_pkg.sv
// Shared types and defaults for the multi-channel serial-to-parallel converter.
// Optional frame alignment is selected with S2P_FRAME_ALIGN_EN.
package s2p_pkg;

  typedef enum logic {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } s2p_state_e;

  localparam int S2P_WIDTH_DEF    = 16;
  localparam int S2P_CHANNELS_DEF = 2;
  localparam int S2P_SYNC_DEF     = 2;

endpackage

// File: rtl/s2p_edge_sync.sv
// Synchroniser bank for DCLK, Frame and Serial plus DCLK fall detector.
// All lanes share one chain depth so they stay mutually aligned.
module s2p_edge_sync
  import s2p_pkg::*;
#(
  parameter int CHANNELS    = S2P_CHANNELS_DEF,
  parameter int SYNC_STAGES = S2P_SYNC_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dclk_i,
  input  logic                frame_i,
  input  logic [CHANNELS-1:0] serial_i,
  output logic                samp_o,
  output logic                frame_o,
  output logic [CHANNELS-1:0] serial_o
);

  localparam int N = CHANNELS + 2;

  logic [N-1:0] sync_q [SYNC_STAGES];
  logic [N-1:0] sync_d [SYNC_STAGES];
  logic [N-1:0] align_q, align_d;
  logic         prev_q, prev_d;

  always_comb begin
    sync_d[0] = {serial_i, frame_i, dclk_i};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    align_d = sync_q[SYNC_STAGES-1];
    prev_d  = align_q[0];
  end

  // prev resets to 0 so the cleared chain can never look like a fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      align_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      align_q <= align_d;
      prev_q  <= prev_d;
    end
  end

  assign samp_o   = prev_q & ~align_q[0];
  assign frame_o  = align_q[1];
  assign serial_o = align_q[N-1:2];

endmodule

// File: rtl/s2p_multi.sv
// Multi-channel serial-to-parallel converter with valid/ready output.
// Define S2P_FRAME_ALIGN_EN to enable HUNT/SHIFT frame-sync alignment.
module s2p_multi
  import s2p_pkg::*;
#(
  parameter int WIDTH       = S2P_WIDTH_DEF,
  parameter int CHANNELS    = S2P_CHANNELS_DEF,
  parameter int SYNC_STAGES = S2P_SYNC_DEF
) (
  input  logic                      SCLK,
  input  logic                      clear,
  input  logic                      DCLK,
  input  logic                      Frame,
  input  logic [CHANNELS-1:0]       Serial,
  output logic [CHANNELS*WIDTH-1:0] Parallel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      overrun,
  output logic                      frame_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic                samp;
  logic                frame_s;
  logic [CHANNELS-1:0] serial_s;

  s2p_edge_sync #(
    .CHANNELS    (CHANNELS),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (SCLK),
    .rst_n    (clear),
    .dclk_i   (DCLK),
    .frame_i  (Frame),
    .serial_i (Serial),
    .samp_o   (samp),
    .frame_o  (frame_s),
    .serial_o (serial_s)
  );

  logic [CHANNELS-1:0][WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [CHANNELS*WIDTH-1:0]      par_q, par_d;
  logic                           valid_q, valid_d;
  logic                           ovr_q, ovr_d;
  logic                           done;

`ifdef S2P_FRAME_ALIGN_EN
  s2p_state_e state_q, state_d;
  logic       ferr_q, ferr_d;
`else
  logic       unused_frame;
  assign unused_frame = frame_s;
`endif

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    done  = 1'b0;
`ifdef S2P_FRAME_ALIGN_EN
    state_d = state_q;
    ferr_d  = 1'b0;
`endif
    if (samp) begin
      for (int c = 0; c < CHANNELS; c++) begin
        sr_d[c] = {sr_q[c][WIDTH-2:0], serial_s[c]};
      end
`ifdef S2P_FRAME_ALIGN_EN
      unique case (state_q)
        HUNT: begin
          if (frame_s) begin
            cnt_d   = CNT_ONE;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (frame_s && cnt_q != '0) begin
            ferr_d = 1'b1;
            cnt_d  = CNT_ONE;
          end else if (cnt_q == CNT_LAST) begin
            done    = 1'b1;
            cnt_d   = '0;
            state_d = HUNT;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      endcase
`else
      if (cnt_q == CNT_LAST) begin
        done  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
`endif
    end
  end

  // a completion always wins over an accept in the same cycle
  always_comb begin
    par_d   = par_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (done) begin
      par_d   = sr_d;
      valid_d = 1'b1;
      ovr_d   = valid_q & ~out_ready;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge SCLK or negedge clear) begin
    if (!clear) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      par_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef S2P_FRAME_ALIGN_EN
  always_ff @(posedge SCLK or negedge clear) begin
    if (!clear) begin
      state_q <= HUNT;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ferr_q  <= ferr_d;
    end
  end

  assign frame_err = ferr_q;
`else
  assign frame_err = 1'b0;
`endif

  assign Parallel  = par_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;

endmodule
